// File: rtl/acq_store_if.sv
// acq_store_if: record stream from the disc reader plus the acquisition RAM
// write port, bundled so acq_store_ctrl has one bus port.
//   WR_DATA/WR_STROBE : record and one-cycle valid from the reader
//   RAM_READY         : RAM owned by this block this cycle
//   RAM_ADDR/DATA/WE  : sequential word writes into acquisition RAM
// master = reader/RAM side, slave = acq_store_ctrl.
interface acq_store_if #(
  parameter int BITS      = 16,
  parameter int ADDR_BITS = 19
) ();
  logic [BITS-1:0]      WR_DATA;
  logic                 WR_STROBE;
  logic                 RAM_READY;
  logic [ADDR_BITS-1:0] RAM_ADDR;
  logic [BITS-1:0]      RAM_DATA;
  logic                 RAM_WE;

  modport master (output WR_DATA, WR_STROBE, RAM_READY,
                  input  RAM_ADDR, RAM_DATA, RAM_WE);
  modport slave  (input  WR_DATA, WR_STROBE, RAM_READY,
                  output RAM_ADDR, RAM_DATA, RAM_WE);
endinterface

// File: rtl/acq_store_ctrl.sv
// acq_store_ctrl: takes the disc reader's record stream and stores it
// sequentially in acquisition RAM through a small FIFO that rides out
// periods where the host owns the RAM. Drives the reader's RUN and ends the
// acquisition on index count, RAM full, FIFO overrun or abort.
// Ports:
//   CLOCK, RESET_N          : clock, async active-low reset
//   START, ABORT            : one-cycle control pulses
//   START_ON_INDEX          : sampled at START, skip records until index flag
//   INDEX_LIMIT             : sampled at START, index edges before stop (0=off)
//   bus                     : record stream in, RAM write port out
//   ACQ_RUN, BUSY, DONE     : status; DONE sticky until next START
//   STOP_REASON             : 0 abort, 1 index, 2 RAM full, 3 overrun
module acq_store_ctrl #(
  parameter int BITS       = 16,
  parameter int ADDR_BITS  = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic        START_ON_INDEX,
  input  logic [7:0]  INDEX_LIMIT,
  acq_store_if.slave  bus,
  output logic        ACQ_RUN,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  STOP_REASON
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_INDEX, ACQ, DRAIN, FINISHED} state_t;
  state_t state;

  logic [BITS-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          fifo_cnt;
  logic [7:0]           idx_cnt, idx_limit, idx_next;
  logic                 prev_flag;
  logic                 we_q;
  logic [BITS-1:0]      data_q;
  logic [ADDR_BITS-1:0] addr_q;

  logic busy_st, fifo_empty, fifo_full, rec_flag, accept, pop_avail;
  logic overrun, push, pop, push_store, pop_mem, is_edge, idx_stop;
  logic wr_done, ram_full, drain_done;
  logic [BITS-1:0] pop_data;

  assign busy_st    = state inside {WAIT_INDEX, ACQ, DRAIN};
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign rec_flag   = bus.WR_DATA[BITS-1];
  assign accept     = bus.WR_STROBE &&
                      (state == ACQ || (state == WAIT_INDEX && rec_flag));
  // A pop this cycle frees a slot, so a full FIFO only overruns when the RAM
  // is unavailable.
  assign pop_avail  = busy_st && bus.RAM_READY;
  assign overrun    = accept && fifo_full && !pop_avail;
  assign push       = accept && !overrun;
  assign pop        = pop_avail && (!fifo_empty || push);
  // Empty FIFO: the incoming record goes straight to the write register.
  assign push_store = push && !(pop && fifo_empty);
  assign pop_mem    = pop && !fifo_empty;
  assign pop_data   = fifo_empty ? bus.WR_DATA : fifo_mem[rd_ptr];

  // The first flagged record in WAIT_INDEX is always an edge.
  assign is_edge  = accept && rec_flag && (state == WAIT_INDEX || !prev_flag);
  assign idx_next = (is_edge && idx_cnt != 8'hFF) ? idx_cnt + 8'd1 : idx_cnt;
  assign idx_stop = push && is_edge && idx_limit != 8'd0 && idx_next == idx_limit;

  // A registered write is held until RAM_READY so RAM_WE never fires while
  // the host owns the RAM.
  assign wr_done    = we_q && bus.RAM_READY;
  assign ram_full   = wr_done && (&addr_q);
  assign drain_done = (state == DRAIN) && fifo_empty && (!we_q || bus.RAM_READY);

  assign bus.RAM_WE   = wr_done;
  assign bus.RAM_ADDR = addr_q;
  assign bus.RAM_DATA = data_q;
  assign ACQ_RUN      = state inside {WAIT_INDEX, ACQ};
  assign BUSY         = busy_st;

  always_ff @(posedge CLOCK)
    if (push_store) fifo_mem[wr_ptr] <= bus.WR_DATA;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      idx_cnt     <= '0;
      idx_limit   <= '0;
      prev_flag   <= 1'b0;
      we_q        <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      DONE        <= 1'b0;
      STOP_REASON <= '0;
    end else begin
      if (wr_done) addr_q <= addr_q + 1'b1;
      case (state)
        IDLE, FINISHED: begin
          if (START) begin
            addr_q      <= '0;
            idx_cnt     <= '0;
            idx_limit   <= INDEX_LIMIT;
            prev_flag   <= 1'b0;
            DONE        <= 1'b0;
            STOP_REASON <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            state       <= START_ON_INDEX ? WAIT_INDEX : ACQ;
          end
        end
        default: begin
          if (accept) begin
            idx_cnt   <= idx_next;
            prev_flag <= rec_flag;
          end
          if (push_store) wr_ptr <= wr_ptr + 1'b1;
          if (pop_mem)    rd_ptr <= rd_ptr + 1'b1;
          if (push_store && !pop_mem)      fifo_cnt <= fifo_cnt + 1'b1;
          else if (!push_store && pop_mem) fifo_cnt <= fifo_cnt - 1'b1;
          if (pop) begin
            we_q   <= 1'b1;
            data_q <= pop_data;
          end else if (wr_done) begin
            we_q <= 1'b0;
          end

          // Priority: abort, RAM full, input-side stops, drain complete.
          if (ABORT || ram_full) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            we_q        <= 1'b0;
            DONE        <= 1'b1;
            STOP_REASON <= ABORT ? 2'd0 : 2'd2;
            state       <= FINISHED;
          end else if (idx_stop || overrun) begin
            STOP_REASON <= overrun ? 2'd3 : 2'd1;
            state       <= DRAIN;
          end else if (drain_done) begin
            DONE  <= 1'b1;
            state <= FINISHED;
          end else if (state == WAIT_INDEX && push) begin
            state <= ACQ;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_acq_store_ctrl.sv
// tb_acq_store_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based transaction model of the controller.
module tb_acq_store_ctrl;
  localparam int BITS = 16, AB = 4, DEPTH = 4;

  logic CLOCK = 1'b0;
  logic RESET_N, start, abort, soi;
  logic [7:0] lim;
  logic ACQ_RUN, BUSY, DONE;
  logic [1:0] STOP_REASON;
  int total = 0, bad = 0;

  acq_store_if #(.BITS(BITS), .ADDR_BITS(AB)) bus ();

  acq_store_ctrl #(.BITS(BITS), .ADDR_BITS(AB), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(start), .ABORT(abort),
    .START_ON_INDEX(soi), .INDEX_LIMIT(lim), .bus(bus),
    .ACQ_RUN(ACQ_RUN), .BUSY(BUSY), .DONE(DONE), .STOP_REASON(STOP_REASON));

  always #5 CLOCK = ~CLOCK;

  // write log: {addr, data} of every RAM write seen
  logic [AB+BITS-1:0] wlog[$];
  always @(negedge CLOCK)
    if (bus.RAM_WE === 1'b1) wlog.push_back({bus.RAM_ADDR, bus.RAM_DATA});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: 0 idle, 1 wait-index, 2 acq, 3 drain, 4 finished
  int             m_st, m_cnt, m_reason, m_lim;
  bit             m_pend, m_prev, m_done;
  logic [15:0]    m_pdata;
  logic [AB-1:0]  m_addr;
  logic [15:0]    mq[$];

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_reason = 0; m_lim = 0;
    m_pend = 0; m_prev = 0; m_done = 0; m_pdata = '0; m_addr = '0;
    mq.delete();
  endtask

  task automatic model_step();
    int pre;
    bit wdone, full_hit, acc, is_edge, stop, avail;
    pre = m_st;
    wdone = m_pend && bus.RAM_READY;
    full_hit = wdone && (m_addr == '1);
    if (wdone) begin m_addr++; m_pend = 0; end
    if (!(pre inside {1, 2, 3})) begin
      if (start) begin
        m_addr = '0; m_cnt = 0; m_prev = 0; m_done = 0; m_reason = 0;
        mq.delete(); m_lim = lim; m_st = soi ? 1 : 2;
      end
      return;
    end
    if (abort) begin
      mq.delete(); m_pend = 0; m_done = 1; m_reason = 0; m_st = 4;
      return;
    end
    stop = 0;
    avail = bus.RAM_READY;
    acc = bus.WR_STROBE && (pre == 2 || (pre == 1 && bus.WR_DATA[15]));
    if (acc) begin
      is_edge = bus.WR_DATA[15] && (pre == 1 || !m_prev);
      m_prev = bus.WR_DATA[15];
      if (is_edge && m_cnt < 255) m_cnt++;
      if (mq.size() == DEPTH && !avail) begin
        stop = 1; m_reason = 3;
      end else begin
        mq.push_back(bus.WR_DATA);
        if (is_edge && m_lim != 0 && m_cnt == m_lim) begin stop = 1; m_reason = 1; end
        else if (pre == 1) m_st = 2;
      end
    end
    if (avail && mq.size() > 0) begin m_pdata = mq.pop_front(); m_pend = 1; end
    if (full_hit) begin
      mq.delete(); m_pend = 0; m_reason = 2; m_done = 1; m_st = 4;
    end else if (stop) begin
      m_st = 3;
    end else if (pre == 3 && mq.size() == 0 && !m_pend) begin
      m_done = 1; m_st = 4;
    end
  endtask

  // One clock: compare outputs with the model, advance the model, clock.
  task automatic cyc();
    bit exp_we;
    #1;
    exp_we = m_pend && bus.RAM_READY;
    chk("acq_run", ACQ_RUN, m_st == 1 || m_st == 2);
    chk("busy", BUSY, m_st inside {1, 2, 3});
    chk("done", DONE, m_done);
    if (m_done) chk("reason", STOP_REASON, m_reason);
    chk("ram_addr", bus.RAM_ADDR, m_addr);
    chk("ram_we", bus.RAM_WE, exp_we);
    if (exp_we) chk("ram_data", bus.RAM_DATA, m_pdata);
    model_step();
    @(posedge CLOCK); #1;
    start = 0; abort = 0; bus.WR_STROBE = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic go(input bit s, input logic [7:0] l);
    soi = s; lim = l; start = 1; cyc();
  endtask

  task automatic strobe(input logic [15:0] d);
    bus.WR_STROBE = 1; bus.WR_DATA = d; cyc();
  endtask

  task automatic chk_log(input string tag, input logic [AB+BITS-1:0] e[$]);
    chk({tag, "_cnt"}, wlog.size(), e.size());
    for (int i = 0; i < e.size() && i < wlog.size(); i++) chk(tag, wlog[i], e[i]);
  endtask

  initial begin
    logic [AB+BITS-1:0] e[$];
    logic [15:0] r;
    RESET_N = 1; start = 0; abort = 0; soi = 0; lim = 0;
    bus.WR_DATA = '0; bus.WR_STROBE = 0; bus.RAM_READY = 1;
    model_reset();
    #1 RESET_N = 0;
    #1;
    chk("rst_run", ACQ_RUN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_reason", STOP_REASON, 0);
    chk("rst_we", bus.RAM_WE, 0);
    chk("rst_addr", bus.RAM_ADDR, 0);
    @(posedge CLOCK); #1 RESET_N = 1;

    // index limit 2
    wlog.delete();
    go(0, 8'd2);
    strobe(16'h0012); strobe(16'h8034); strobe(16'h0020); strobe(16'h8005);
    idle(4);
    e = '{{4'd0, 16'h0012}, {4'd1, 16'h8034}, {4'd2, 16'h0020}, {4'd3, 16'h8005}};
    chk_log("t1_wr", e);
    chk("t1_done", DONE, 1); chk("t1_reason", STOP_REASON, 1);
    chk("t1_addr", bus.RAM_ADDR, 4);

    // start on index, then abort
    wlog.delete();
    go(1, 8'd0);
    strobe(16'h0011); strobe(16'h7FFF); strobe(16'h8003); strobe(16'h0040);
    idle(1);
    abort = 1; cyc();
    idle(3);
    e = '{{4'd0, 16'h8003}, {4'd1, 16'h0040}};
    chk_log("t2_wr", e);
    chk("t2_done", DONE, 1); chk("t2_reason", STOP_REASON, 0);
    chk("t2_run", ACQ_RUN, 0);

    // overrun with RAM held by host
    wlog.delete();
    bus.RAM_READY = 0;
    go(0, 8'd0);
    for (int i = 1; i <= 5; i++) strobe(16'h0100 + 16'(i));
    idle(2);
    chk("t3_wait_done", DONE, 0);
    chk("t3_run", ACQ_RUN, 0);
    bus.RAM_READY = 1;
    idle(7);
    e.delete();
    for (int i = 0; i < 4; i++) e.push_back({4'(i), 16'h0101 + 16'(i)});
    chk_log("t3_wr", e);
    chk("t3_reason", STOP_REASON, 3);

    // RAM full
    wlog.delete();
    go(0, 8'd0);
    for (int i = 0; i < 20; i++) strobe(16'h0200 + 16'(i));
    idle(3);
    e.delete();
    for (int i = 0; i < 16; i++) e.push_back({4'(i), 16'h0200 + 16'(i)});
    chk_log("t4_wr", e);
    chk("t4_done", DONE, 1); chk("t4_reason", STOP_REASON, 2);
    chk("t4_addr", bus.RAM_ADDR, 0); chk("t4_run", ACQ_RUN, 0);

    // back-to-back flagged records are one edge
    wlog.delete();
    go(0, 8'd2);
    strobe(16'h8001); strobe(16'h8002);
    idle(3);
    chk("t5_busy", BUSY, 1); chk("t5_run", ACQ_RUN, 1);
    strobe(16'h0005); strobe(16'h8006);
    idle(3);
    chk("t5_cnt", wlog.size(), 4);
    chk("t5_done", DONE, 1); chk("t5_reason", STOP_REASON, 1);

    // async reset with words queued
    bus.RAM_READY = 0;
    go(0, 8'd0);
    strobe(16'h0A01); strobe(16'h0A02); strobe(16'h0A03);
    RESET_N = 0;
    #2;
    chk("t6_run", ACQ_RUN, 0); chk("t6_busy", BUSY, 0);
    chk("t6_done", DONE, 0); chk("t6_reason", STOP_REASON, 0);
    chk("t6_addr", bus.RAM_ADDR, 0); chk("t6_data", bus.RAM_DATA, 0);
    chk("t6_we", bus.RAM_WE, 0);
    model_reset();
    @(posedge CLOCK); #1 RESET_N = 1;
    bus.RAM_READY = 1;
    wlog.delete();
    go(0, 8'd0);
    strobe(16'h0777);
    idle(2);
    e = '{{4'd0, 16'h0777}};
    chk_log("t6_wr", e);
    abort = 1; cyc();

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      bus.RAM_READY = 1;
      go($urandom_range(3) == 0, 8'($urandom_range(4)));
      for (int c = 0; c < 45; c++) begin
        bus.RAM_READY = ($urandom_range(3) != 0);
        if ($urandom_range(1) == 1) begin
          bus.WR_STROBE = 1;
          r = 16'($urandom);
          if ($urandom_range(2) == 0)      bus.WR_DATA = r | 16'h8000;
          else if ($urandom_range(9) == 0) bus.WR_DATA = 16'h7FFF;
          else                             bus.WR_DATA = r & 16'h7FFF;
        end
        abort = ($urandom_range(59) == 0);
        if ($urandom_range(29) == 0) begin
          start = 1; soi = ($urandom_range(3) == 0); lim = 8'($urandom_range(4));
        end
        cyc();
      end
      abort = 1; cyc();
      bus.RAM_READY = 1;
      idle(3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
